// File: rtl/ndp_pkg.sv
// Shared NDP definitions: stream-reader state encoding and output FIFO geometry.
package ndp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = 2'd2;

endpackage

// File: rtl/ndp_skid_fifo.sv
// Two-entry FIFO used as the output skid buffer; head word is presented directly.
module ndp_skid_fifo
  import ndp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem [FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [FIFO_CNT_W-1:0] cnt;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign push_ok = push && ((cnt != FIFO_FULL) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign data  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from BRAM port B (1-cycle read latency) and streams
// them out on a valid/ready interface, wrapping addresses at DEPTH.
module bram_stream_reader
  import ndp_pkg::*;
#(
  parameter int B_WIDTH         = 64,
  parameter int B_ADDRESS_WIDTH = 3,
  parameter int DEPTH           = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [B_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [B_ADDRESS_WIDTH:0]   length,
  output logic                       busy,
  output logic                       done,
  output logic                       enb,
  output logic [B_ADDRESS_WIDTH-1:0] addrb,
  input  logic [B_WIDTH-1:0]         doutb,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [B_WIDTH-1:0]         m_data,
  output logic                       m_last
);

  localparam int AW = B_ADDRESS_WIDTH;
  localparam int CW = B_ADDRESS_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? AW'(0) : a + AW'(1);
  endfunction

  state_t                state, next_state;
  logic [AW-1:0]         addr_r;
  logic [CW-1:0]         len_r;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         accept_cnt;
  logic                  pend_r;
  logic                  done_r;

  logic [AW-1:0]         base_mod;
  logic [CW-1:0]         len_clamp;
  logic                  accept_start;
  logic                  read_issue;
  logic                  pop;
  logic                  credit;
  logic [2:0]            occupancy;
  logic                  fifo_valid;
  logic [B_WIDTH-1:0]    fifo_data;
  logic [FIFO_CNT_W-1:0] fifo_cnt;

  assign base_mod     = AW'(int'(base_addr) % DEPTH);
  assign len_clamp    = (length > DEPTH_C) ? DEPTH_C : length;
  assign accept_start = (state == IDLE) && start && (length != '0);
  assign pop          = fifo_valid && m_ready;

  // Reads whose data is still on its way plus words held, counting the word
  // leaving this cycle as gone so a steady stream runs at one word per cycle.
  assign occupancy  = {2'b00, pend_r} + {1'b0, fifo_cnt};
  assign credit     = occupancy < (3'd2 + {2'b00, pop});
  assign read_issue = (state == READ) && credit && (issue_cnt < len_r);

  assign enb   = accept_start || read_issue;
  assign addrb = accept_start ? base_mod : addr_r;

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_start) next_state = READ;
        else              next_state = IDLE;
      end
      READ: begin
        if ((read_issue && (issue_cnt + CW'(1) == len_r)) || (issue_cnt == len_r))
          next_state = DRAIN;
        else
          next_state = READ;
      end
      DRAIN: begin
        if (pop && m_last) next_state = IDLE;
        else               next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, burst counters, issue address and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_r     <= '0;
      len_r      <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      pend_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state  <= next_state;
      pend_r <= enb;
      done_r <= ((state == IDLE) && start && (length == '0)) ||
                ((state == DRAIN) && pop && m_last);
      if (accept_start) begin
        len_r      <= len_clamp;
        issue_cnt  <= CW'(1);
        accept_cnt <= '0;
        addr_r     <= wrap_inc(base_mod);
      end else begin
        if (read_issue) begin
          issue_cnt <= issue_cnt + CW'(1);
          addr_r    <= wrap_inc(addr_r);
        end
        if (pop) accept_cnt <= accept_cnt + CW'(1);
      end
    end
  end

  ndp_skid_fifo #(.WIDTH(B_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_r),
    .push_data (doutb),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_cnt)
  );

  assign busy    = (state != IDLE);
  assign done    = done_r;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_data;
  assign m_last  = fifo_valid && (accept_cnt == len_r - CW'(1));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a 1-cycle-latency BRAM model plus a
// negedge monitor logging issued addresses, transfers and done pulses.
module tb_bram_stream_reader;

  localparam int BW    = 64;
  localparam int AW    = 3;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, enb, m_valid, m_ready, m_last;
  logic [AW-1:0] addrb;
  logic [BW-1:0] doutb, m_data;

  always #5 clk = ~clk;

  bram_stream_reader #(.B_WIDTH(BW), .B_ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic [BW-1:0] bram [DEPTH];
  always @(posedge clk) if (enb) doutb <= bram[addrb];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            addr_q[$];
  logic [BW-1:0] data_q[$];
  bit            last_q[$];
  int            vcyc_q[$];
  int            done_q[$];
  int            iss = 0, acc = 0, max_out = 0, stall_viol = 0, stall_seen = 0;
  logic [BW-1:0] held_data;
  logic          held_last;
  bit            held_v = 1'b0;

  // Per-cycle monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      iss    = acc;
      held_v = 1'b0;
    end else begin
      if (iss - acc > max_out) max_out = iss - acc;
      if (enb) begin addr_q.push_back(int'(addrb)); iss++; end
      if (held_v && m_valid && (m_data !== held_data || m_last !== held_last)) stall_viol++;
      held_v    = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (held_v) stall_seen++;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data); last_q.push_back(m_last); vcyc_q.push_back(cyc); acc++;
      end
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic do_start(input int b, input int l, output int x);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); length = LW'(l); x = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done_q.size() > n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_last, m_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b enb=%b addrb=%0d m_valid=%b m_last=%b m_data=%h, required all 0",
                         busy, done, enb, addrb, m_valid, m_last, m_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int a0, d0, n0, x; bit ok;
    a0 = addr_q.size(); d0 = data_q.size(); n0 = done_q.size();
    do_start(1, 3, x);
    wait_done(n0, ok);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!ok || addr_q.size() - a0 != 3 || data_q.size() - d0 != 3) begin
      errors++; $display("FAIL basic_counts: got done=%b reads=%0d words=%0d, required 1/3/3", ok, addr_q.size() - a0, data_q.size() - d0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr_q[a0+i] != 1 + i || data_q[d0+i] !== bram[1+i] || vcyc_q[d0+i] != x + 2 + i || last_q[d0+i] != (i == 2)) begin
          errors++; $display("FAIL basic_word%0d: got addr=%0d data=%h cyc=%0d last=%b, required addr=%0d data=%h cyc=%0d last=%b",
                             i, addr_q[a0+i], data_q[d0+i], vcyc_q[d0+i] - x, last_q[d0+i], 1 + i, bram[1+i], 2 + i, i == 2);
        end
      end
      checks++;
      if (done_q[n0] != x + 5 || done_q.size() != n0 + 1 || busy !== 1'b0) begin
        errors++; $display("FAIL basic_done: got done at %0d (pulses %0d) busy=%b, required 5 (1) busy=0", done_q[n0] - x, done_q.size() - n0, busy);
      end
    end
  endtask

  task automatic test_wrap(input int b, input int l, input int first, input int n);
    int a0, d0, n0, x, ea; bit ok;
    a0 = addr_q.size(); d0 = data_q.size(); n0 = done_q.size();
    do_start(b, l, x);
    wait_done(n0, ok);
    #1;
    checks++;
    if (!ok || addr_q.size() - a0 != n || data_q.size() - d0 != n) begin
      errors++; $display("FAIL wrap_counts b=%0d l=%0d: got done=%b reads=%0d words=%0d, required 1/%0d/%0d", b, l, ok, addr_q.size() - a0, data_q.size() - d0, n, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = (first + i) % DEPTH;
        checks++;
        if (addr_q[a0+i] != ea || data_q[d0+i] !== bram[ea] || last_q[d0+i] != (i == n - 1)) begin
          errors++; $display("FAIL wrap_word%0d b=%0d: got addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                             i, b, addr_q[a0+i], data_q[d0+i], last_q[d0+i], ea, bram[ea], i == n - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int d0, n0, s0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    d0 = data_q.size(); n0 = done_q.size(); s0 = stall_seen;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(0); length = LW'(4); m_ready = pat[0];
    for (int k = 1; k < 80; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      m_ready = pat[k % 4];
      if (done_q.size() > n0) break;
    end
    m_ready = 1'b1;
    checks++;
    if (done_q.size() != n0 + 1 || data_q.size() - d0 != 4) begin
      errors++; $display("FAIL bp_counts: got done=%0d words=%0d, required 1/4", done_q.size() - n0, data_q.size() - d0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (data_q[d0+i] !== bram[i] || last_q[d0+i] != (i == 3)) begin
          errors++; $display("FAIL bp_word%0d: got data=%h last=%b, required data=%h last=%b", i, data_q[d0+i], last_q[d0+i], bram[i], i == 3);
        end
      end
    end
    checks++;
    if (stall_viol != 0 || stall_seen == s0) begin
      errors++; $display("FAIL bp_stable: got violations=%0d stalls=%0d, required 0 violations and >0 stalls", stall_viol, stall_seen - s0);
    end
    checks++;
    if (max_out > 2) begin
      errors++; $display("FAIL bp_outstanding: got %0d, required <=2", max_out);
    end
  endtask

  task automatic test_zero_len();
    int a0, d0, n0, x;
    a0 = addr_q.size(); d0 = data_q.size(); n0 = done_q.size();
    do_start(2, 0, x);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (addr_q.size() != a0 || data_q.size() != d0 || done_q.size() != n0 + 1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_len: got reads=%0d words=%0d dones=%0d busy=%b, required 0/0/1/0",
                         addr_q.size() - a0, data_q.size() - d0, done_q.size() - n0, busy);
    end else begin
      checks++;
      if (done_q[n0] != x + 1) begin
        errors++; $display("FAIL zero_len_done_cycle: got %0d, required 1", done_q[n0] - x);
      end
    end
  endtask

  task automatic test_mid_reset();
    int d0, n0, x; bit got2; bit ok;
    d0 = data_q.size();
    do_start(0, 5, x);
    got2 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (data_q.size() >= d0 + 2) begin got2 = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got2) begin errors++; $display("FAIL midrst_wait: got %0d words, required 2", data_q.size() - d0); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_last, m_data} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b done=%b enb=%b addrb=%0d m_valid=%b m_last=%b m_data=%h, required all 0",
                         busy, done, enb, addrb, m_valid, m_last, m_data);
    end
    d0 = data_q.size(); n0 = done_q.size();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (data_q.size() != d0 || done_q.size() != n0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: got words=%0d dones=%0d busy=%b, required 0/0/0", data_q.size() - d0, done_q.size() - n0, busy);
    end
    do_start(0, 2, x);
    wait_done(n0, ok);
    checks++;
    if (!ok || data_q.size() - d0 != 2) begin
      errors++; $display("FAIL midrst_restart: got done=%b words=%0d, required 1/2", ok, data_q.size() - d0);
    end else begin
      checks++;
      if (data_q[d0] !== bram[0] || data_q[d0+1] !== bram[1] || last_q[d0] != 1'b0 || last_q[d0+1] != 1'b1) begin
        errors++; $display("FAIL midrst_data: got %h/%b %h/%b, required %h/0 %h/1", data_q[d0], last_q[d0], data_q[d0+1], last_q[d0+1], bram[0], bram[1]);
      end
    end
  endtask

  task automatic test_busy_restart();
    int a0, d0, n0, x; bit ok;
    a0 = addr_q.size(); d0 = data_q.size(); n0 = done_q.size();
    do_start(2, 3, x);
    start = 1'b1; base_addr = AW'(0); length = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n0, ok);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (!ok || addr_q.size() - a0 != 3 || data_q.size() - d0 != 3 || done_q.size() != n0 + 1) begin
      errors++; $display("FAIL busy_counts: got done=%b reads=%0d words=%0d dones=%0d, required 1/3/3/1",
                         ok, addr_q.size() - a0, data_q.size() - d0, done_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr_q[a0+i] != 2 + i || data_q[d0+i] !== bram[2+i] || last_q[d0+i] != (i == 2)) begin
          errors++; $display("FAIL busy_word%0d: got addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                             i, addr_q[a0+i], data_q[d0+i], last_q[d0+i], 2 + i, bram[2+i], i == 2);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0101_0101_0101;
    test_reset();
    test_basic();
    test_wrap(3, 5, 3, 5);
    test_wrap(6, 7, 1, 5);
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_busy_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter B_WIDTH, default 64, BRAM port-B data width.
REQ-002 SHALL have parameter B_ADDRESS_WIDTH, default 3, BRAM port-B address width.
REQ-003 SHALL have parameter DEPTH, default 5, number of valid B_WIDTH words in the BRAM.
REQ-004 SHALL have port clk, input, 1, sole clock; everything is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr, input, B_ADDRESS_WIDTH, first word address, sampled with start.
REQ-008 SHALL have port length, input, B_ADDRESS_WIDTH+1, word count, sampled with start.
REQ-009 SHALL have port busy, output, 1, high from accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the last word is accepted downstream.
REQ-011 SHALL have port enb, output, 1, BRAM port-B read enable.
REQ-012 SHALL have port addrb, output, B_ADDRESS_WIDTH, BRAM port-B address.
REQ-013 SHALL have port doutb, input, B_WIDTH, BRAM read data, valid one clk after the enb/addrb issue.
REQ-014 SHALL have port m_valid, output, 1, output word valid.
REQ-015 SHALL have port m_ready, input, 1, downstream ready.
REQ-016 SHALL have port m_data, output, B_WIDTH, output word.
REQ-017 SHALL have port m_last, output, 1, marks the final word of a burst.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start with length!=0; READ->DRAIN when the last read is issued; DRAIN->IDLE when the last word transfers (m_valid&m_ready&m_last).
REQ-019 SHALL, on start with length==0 in IDLE, pulse done the next cycle, stay IDLE, and issue no reads.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL increment the issue address by 1 per issued read and wrap from DEPTH-1 to 0; base_addr>=DEPTH is reduced modulo DEPTH at capture.
REQ-022 SHALL issue a read (enb=1) only when in-flight reads plus buffered words is less than 2.
REQ-023 SHALL capture doutb the cycle after issue into a 2-entry output FIFO; no word SHALL ever be dropped or duplicated.
REQ-024 SHALL give a latency of 2 cycles from start to the first m_valid when m_ready is held high.
REQ-025 SHALL sustain 1 word/cycle when m_ready is held high.
REQ-026 SHALL hold m_data/m_last stable while m_valid=1 and m_ready=0.
REQ-027 SHALL assert m_last only with the word numbered length-1 of the burst.
REQ-028 SHALL handle a simultaneous FIFO push and pop without changing occupancy.
REQ-029 SHALL use an issue counter and an accept counter, each B_ADDRESS_WIDTH+1 bits wide, with no overflow for length<=DEPTH; length>DEPTH is clamped to DEPTH.

Reset
REQ-030 SHALL, on rst, asynchronously force state=IDLE, busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0, and both counters and FIFO occupancy to 0.
REQ-031 SHALL discard any burst in progress on rst mid-operation, with no done pulse, and SHALL discard read data returning after reset.

Structure
REQ-032 SHALL place the state encoding and the FIFO depth constant (2) in the shared NDP package.
REQ-033 SHALL implement the 2-entry FIFO as a sub-module named ndp_skid_fifo.

Verification
REQ-034 SHALL test that start, base=1, length=3, m_ready=1 -> reads issued at addresses 1,2,3; m_valid on cycles 2-4; m_last on the third word; done one cycle later.
REQ-035 SHALL test wrap: base=3, length=5 -> address sequence 3,4,0,1,2 and data matching the preloaded words.
REQ-036 SHALL test backpressure: m_ready toggling 1,0,0,1 with length=4 -> all 4 words delivered in order, data stable while stalled, and no more than 2 reads outstanding.
REQ-037 SHALL test length=0 -> done pulses one cycle after start, enb never asserted, and m_valid never asserted.
REQ-038 SHALL test rst asserted mid-burst after 2 words -> all outputs 0 immediately; a new start, base=0, length=2, then completes normally.
REQ-039 SHALL test start reasserted while busy -> ignored, with the burst count and addresses unchanged.
